// File: rtl/manch_pkg.sv
// Shared types for the Manchester receive path: FSM states and error codes.
package manch_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    DATA,
    STOP
  } rx_state_e;

  localparam logic [1:0] ERR_VIOL = 2'b01;
  localparam logic [1:0] ERR_STOP = 2'b10;

endpackage

// File: rtl/manch_sync.sv
// Two-flop synchroniser for the Manchester line plus a registered copy for edge strobes.
module manch_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q, prev_q;

  // Reset to the idle-high level so leaving reset never looks like a start edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~prev_q;
  assign fall_o  = ~sync2_q & prev_q;

endmodule

// File: rtl/manch_decoding_rx.sv
// Manchester UART-frame receiver (start 0, 8 data LSB first, stop 1), mid-bit sampled.
// Define MANCH_RESYNC_EN to re-centre the bit phase on every mid-bit edge.
//
// state     | meaning
// WAIT_IDLE | qualifying idle: need FULLBAUD consecutive high samples
// IDLE      | waiting for the start-bit mid-bit falling edge
// DATA      | sampling the 8 data bits (A in first half, B in second half)
// STOP      | sampling the stop bit, then deliver byte or flag error
module manch_decoding_rx
  import manch_pkg::*;
#(
  parameter int BAUDRATE = 115200,
  parameter int CLK_FREQ = 18_750_000
) (
  input  logic       mclkin,
  input  logic       rst,
  input  logic       rx_manch,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [1:0] rx_err_code,
  output logic       rx_busy
);

  localparam int FULLBAUD = CLK_FREQ / BAUDRATE;
  localparam int HALFBAUD = FULLBAUD / 2;
  localparam int QUARTER  = HALFBAUD / 2;
  localparam int PW       = $clog2(FULLBAUD);

  localparam logic [PW-1:0] PH_LAST = PW'(FULLBAUD - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(HALFBAUD);
  localparam logic [PW-1:0] PH_Q    = PW'(QUARTER);
  localparam logic [PW-1:0] PH_HQ   = PW'(HALFBAUD + QUARTER);

  logic line_lvl, line_rise, line_fall;

  manch_sync u_sync (
    .clk_i  (mclkin),
    .rst_i  (rst),
    .line_i (rx_manch),
    .level_o(line_lvl),
    .rise_o (line_rise),
    .fall_o (line_fall)
  );

  rx_state_e      state_q, state_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [2:0]     bit_q, bit_d;
  logic           a_q, a_d, a_vld_q, a_vld_d;
  logic [7:0]     shift_q, shift_d, data_q, data_d;
  logic           valid_q, valid_d, err_q, err_d, busy_q, busy_d;
  logic [1:0]     code_q, code_d;
  logic           resync;

`ifdef MANCH_RESYNC_EN
  assign resync = (line_rise | line_fall) && (phase_q > PH_Q) && (phase_q < PH_HQ);
`else
  logic unused_rise;
  assign unused_rise = line_rise;
  assign resync      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    a_d     = a_q;
    a_vld_d = a_vld_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    busy_d  = busy_q;
    unique case (state_q)
      WAIT_IDLE: begin
        busy_d = 1'b0;
        if (!line_lvl) begin
          phase_d = '0;
        end else if (phase_q == PH_LAST) begin
          phase_d = '0;
          state_d = IDLE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      IDLE: begin
        if (line_fall) begin
          phase_d = PH_HALF;
          bit_d   = 3'd0;
          a_vld_d = 1'b0;
          busy_d  = 1'b1;
          state_d = DATA;
        end
      end
      DATA, STOP: begin
        if (resync)                  phase_d = PH_HALF;
        else if (phase_q == PH_LAST) phase_d = '0;
        else                         phase_d = phase_q + 1'b1;
        if (phase_q == PH_Q) begin
          a_d     = line_lvl;
          a_vld_d = 1'b1;
        end
        // a_vld_q keeps the tail of the start bit from being taken as a sample B.
        if (phase_q == PH_HQ && a_vld_q) begin
          if (a_q == line_lvl) begin
            err_d   = 1'b1;
            code_d  = ERR_VIOL;
            busy_d  = 1'b0;
            phase_d = '0;
            state_d = WAIT_IDLE;
          end else if (state_q == DATA) begin
            shift_d = {line_lvl, shift_q[7:1]};
          end else if (!line_lvl) begin
            err_d   = 1'b1;
            code_d  = ERR_STOP;
            busy_d  = 1'b0;
            phase_d = '0;
            state_d = WAIT_IDLE;
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        if (state_q == DATA && phase_q == PH_LAST && a_vld_q) begin
          a_vld_d = 1'b0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge mclkin) begin
    if (rst) begin
      state_q <= WAIT_IDLE;
      phase_q <= '0;
      bit_q   <= 3'd0;
      a_q     <= 1'b0;
      a_vld_q <= 1'b0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      a_q     <= a_d;
      a_vld_q <= a_vld_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_err      = err_q;
  assign rx_err_code = code_q;
  assign rx_busy     = busy_q;

endmodule
